// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg: ID/EX pipeline register with load-use hazard detection, hold and flush handling.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   Op_i                  opcode of the instruction in ID (selects which source registers it reads)
//   ALUOp_i .. MemtoReg_i control bits from the Control decoder
//   RS1data_i, RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i   ID operands
//   Stall_i               downstream hold request
//   Flush_i               branch taken; squash the instruction in ID
//   ALUOp_o .. RDaddr_o   registered EX-stage copies
//   NoOp_o                0 tells Control to emit a bubble
//   PCWrite_o, IFIDWrite_o  front-end write enables
//
// Optional feature: define ID_EX_PERF_CNT_EN to add BubbleCnt_o / HoldCnt_o counters.
module id_ex_hazard_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [6:0]        Op_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              ALUSrc_i,
    input  logic              Branch_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic [DATA_W-1:0] RS1data_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [9:0]        funct_i,
    input  logic [REG_AW-1:0] RS1addr_i,
    input  logic [REG_AW-1:0] RS2addr_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    input  logic              Stall_i,
    input  logic              Flush_i,
    output logic [1:0]        ALUOp_o,
    output logic              ALUSrc_o,
    output logic              Branch_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [9:0]        funct_o,
    output logic [REG_AW-1:0] RS1addr_o,
    output logic [REG_AW-1:0] RS2addr_o,
    output logic [REG_AW-1:0] RDaddr_o,
    output logic              NoOp_o,
    output logic              PCWrite_o,
    output logic              IFIDWrite_o
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       BubbleCnt_o,
    output logic [31:0]       HoldCnt_o
`endif
);
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    logic [7:0]        ctrl_q, ctrl_d, ctrl_in;
    logic [DATA_W-1:0] rs1data_q, rs1data_d;
    logic [DATA_W-1:0] rs2data_q, rs2data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [9:0]        funct_q, funct_d;
    logic [REG_AW-1:0] rs1addr_q, rs1addr_d;
    logic [REG_AW-1:0] rs2addr_q, rs2addr_d;
    logic [REG_AW-1:0] rdaddr_q, rdaddr_d;
    logic              pend_q, pend_d;
    logic              use_rs1, use_rs2, hazard, kill;
    assign ctrl_in = {ALUOp_i, ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i};
    assign use_rs1 = (Op_i == OP_IMM) | (Op_i == OP_REG) | (Op_i == OP_LD) | (Op_i == OP_ST) | (Op_i == OP_BR);
    assign use_rs2 = (Op_i == OP_REG) | (Op_i == OP_ST) | (Op_i == OP_BR);
    // ctrl_q[3] is the EX-stage MemRead: a load whose result is not yet available.
    assign hazard = ctrl_q[3] & (rdaddr_q != '0) &
                    ((use_rs1 & (RS1addr_i == rdaddr_q)) | (use_rs2 & (RS2addr_i == rdaddr_q)));
    // A flush seen during a hold is remembered and applied on the first released edge.
    assign kill = Flush_i | pend_q;
    always_comb begin
        ctrl_d    = Stall_i ? ctrl_q : (kill ? 8'b0 : ctrl_in);
        rs1data_d = Stall_i ? rs1data_q : RS1data_i;
        rs2data_d = Stall_i ? rs2data_q : RS2data_i;
        imm_d     = Stall_i ? imm_q : Imm_i;
        funct_d   = Stall_i ? funct_q : funct_i;
        rs1addr_d = Stall_i ? rs1addr_q : RS1addr_i;
        rs2addr_d = Stall_i ? rs2addr_q : RS2addr_i;
        rdaddr_d  = Stall_i ? rdaddr_q : RDaddr_i;
        pend_d    = Stall_i ? (pend_q | Flush_i) : 1'b0;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q    <= '0;
            rs1data_q <= '0;
            rs2data_q <= '0;
            imm_q     <= '0;
            funct_q   <= '0;
            rs1addr_q <= '0;
            rs2addr_q <= '0;
            rdaddr_q  <= '0;
            pend_q    <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            rs1data_q <= rs1data_d;
            rs2data_q <= rs2data_d;
            imm_q     <= imm_d;
            funct_q   <= funct_d;
            rs1addr_q <= rs1addr_d;
            rs2addr_q <= rs2addr_d;
            rdaddr_q  <= rdaddr_d;
            pend_q    <= pend_d;
        end
    end
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, hold_cnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_q + 32'(~Stall_i & (kill | hazard));
            hold_cnt_q   <= hold_cnt_q + 32'(Stall_i);
        end
    end
    assign BubbleCnt_o = bubble_cnt_q;
    assign HoldCnt_o   = hold_cnt_q;
`endif
    assign {ALUOp_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o, MemtoReg_o} = ctrl_q;
    assign RS1data_o   = rs1data_q;
    assign RS2data_o   = rs2data_q;
    assign Imm_o       = imm_q;
    assign funct_o     = funct_q;
    assign RS1addr_o   = rs1addr_q;
    assign RS2addr_o   = rs2addr_q;
    assign RDaddr_o    = rdaddr_q;
    assign NoOp_o      = ~hazard;
    assign PCWrite_o   = ~(hazard | Stall_i);
    assign IFIDWrite_o = ~(hazard | Stall_i);
endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb_id_ex_hazard_reg: scoreboard bench for the ID/EX register and its load-use hazard logic.
module tb_id_ex_hazard_reg;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [7:0] C_LW   = 8'b00101011;
    localparam logic [7:0] C_ADD  = 8'b10000010;
    logic        clk_i = 0, rst_i = 1;
    logic [6:0]  Op_i = 0;
    logic [1:0]  ALUOp_i = 0;
    logic        ALUSrc_i = 0, Branch_i = 0, MemRead_i = 0, MemWrite_i = 0, RegWrite_i = 0, MemtoReg_i = 0;
    logic [31:0] RS1data_i = 0, RS2data_i = 0, Imm_i = 0;
    logic [9:0]  funct_i = 0;
    logic [4:0]  RS1addr_i = 0, RS2addr_i = 0, RDaddr_i = 0;
    logic        Stall_i = 0, Flush_i = 0;
    logic [1:0]  ALUOp_o;
    logic        ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o, MemtoReg_o;
    logic [31:0] RS1data_o, RS2data_o, Imm_o;
    logic [9:0]  funct_o;
    logic [4:0]  RS1addr_o, RS2addr_o, RDaddr_o;
    logic        NoOp_o, PCWrite_o, IFIDWrite_o;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] BubbleCnt_o, HoldCnt_o;
`endif
    int errors = 0, checks = 0;
    logic [7:0]   m_ctrl;
    logic [31:0]  m_rs1d, m_rs2d, m_imm, m_bub, m_hold;
    logic [9:0]   m_funct;
    logic [4:0]   m_a1, m_a2, m_rd;
    logic         m_pend;
    logic [128:0] sb[$];
    logic [128:0] dut_bus, e;
    always #5 clk_i = ~clk_i;
    initial begin
        #500000;
        $display("FAIL timeout reached");
        $fatal(1);
    end
    id_ex_hazard_reg dut (
        .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i),
        .Branch_i(Branch_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i),
        .MemtoReg_i(MemtoReg_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i),
        .funct_i(funct_i), .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
        .Stall_i(Stall_i), .Flush_i(Flush_i), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o),
        .Branch_o(Branch_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .RegWrite_o(RegWrite_o),
        .MemtoReg_o(MemtoReg_o), .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o),
        .funct_o(funct_o), .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
        .NoOp_o(NoOp_o), .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o)
`ifdef ID_EX_PERF_CNT_EN
        , .BubbleCnt_o(BubbleCnt_o), .HoldCnt_o(HoldCnt_o)
`endif
    );
    assign dut_bus = {ALUOp_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o, MemtoReg_o,
                      RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o};
    function automatic logic model_hazard();
        logic u1, u2;
        u1 = Op_i inside {OP_IMM, OP_REG, OP_LD, OP_ST, OP_BR};
        u2 = Op_i inside {OP_REG, OP_ST, OP_BR};
        return m_ctrl[3] && m_rd != 0 && ((u1 && RS1addr_i == m_rd) || (u2 && RS2addr_i == m_rd));
    endfunction
    task automatic drive(input logic [6:0] op, input logic [7:0] c, input logic [4:0] a1, a2, rd,
                         input logic st, fl);
        rst_i = 0;
        Op_i = op;
        {ALUOp_i, ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i} = c;
        RS1addr_i = a1;
        RS2addr_i = a2;
        RDaddr_i = rd;
        RS1data_i = $urandom;
        RS2data_i = $urandom;
        Imm_i = $urandom;
        funct_i = 10'($urandom);
        Stall_i = st;
        Flush_i = fl;
    endtask
    task automatic cycle();
        logic hz;
        hz = model_hazard();
        if (rst_i) begin
            {m_ctrl, m_rs1d, m_rs2d, m_imm, m_funct, m_a1, m_a2, m_rd, m_pend, m_bub, m_hold} = '0;
        end else if (Stall_i) begin
            m_pend = m_pend | Flush_i;
            m_hold = m_hold + 1;
        end else begin
            if (Flush_i || m_pend || hz) m_bub = m_bub + 1;
            m_ctrl = (Flush_i || m_pend) ? 8'b0
                   : {ALUOp_i, ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i};
            {m_rs1d, m_rs2d, m_imm, m_funct, m_a1, m_a2, m_rd} =
                {RS1data_i, RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i};
            m_pend = 0;
        end
        sb.push_back({m_ctrl, m_rs1d, m_rs2d, m_imm, m_funct, m_a1, m_a2, m_rd});
        @(posedge clk_i);
        #1;
    endtask
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(7'($urandom), 8'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'b0, 1'($urandom));
            rst_i = 1;
            cycle();
            e = sb.pop_front();
            checks++;
            if (dut_bus !== '0) begin
                errors++;
                $display("FAIL reset_regs got=%h exp=0", dut_bus);
            end
        end
        drive(OP_REG, C_ADD, 1, 2, 3, 0, 0);
        #1;
        checks++;
        if ({NoOp_o, PCWrite_o, IFIDWrite_o} !== 3'b111) begin
            errors++;
            $display("FAIL reset_comb got=%b exp=111", {NoOp_o, PCWrite_o, IFIDWrite_o});
        end
    endtask
    task automatic test_load_use();
        drive(OP_LD, C_LW, 2, 0, 5, 0, 0);
        cycle();
        e = sb.pop_front();
        checks++;
        if (dut_bus !== e) begin
            errors++;
            $display("FAIL lu_capture got=%h exp=%h", dut_bus, e);
        end
        drive(OP_REG, C_ADD, 1, 5, 7, 0, 0);
        #1;
        checks++;
        if ({NoOp_o, PCWrite_o, IFIDWrite_o} !== 3'b000) begin
            errors++;
            $display("FAIL lu_detect got=%b exp=000", {NoOp_o, PCWrite_o, IFIDWrite_o});
        end
        drive(OP_REG, 8'b0, 1, 5, 7, 0, 0);
        cycle();
        e = sb.pop_front();
        checks++;
        if (dut_bus !== e || RegWrite_o !== 1'b0 || MemRead_o !== 1'b0) begin
            errors++;
            $display("FAIL lu_bubble got=%h exp=%h", dut_bus, e);
        end
        drive(OP_REG, C_ADD, 1, 5, 7, 0, 0);
        #1;
        checks++;
        if ({NoOp_o, PCWrite_o, IFIDWrite_o} !== 3'b111) begin
            errors++;
            $display("FAIL lu_clear got=%b exp=111", {NoOp_o, PCWrite_o, IFIDWrite_o});
        end
        cycle();
        e = sb.pop_front();
        checks++;
        if (dut_bus !== e) begin
            errors++;
            $display("FAIL lu_issue got=%h exp=%h", dut_bus, e);
        end
    endtask
    task automatic test_no_false_hazard();
        logic [6:0] ops[3] = '{OP_REG, OP_IMM, 7'b1111111};
        logic [4:0] rds[3] = '{5'd0, 5'd6, 5'd6};
        for (int i = 0; i < 3; i++) begin
            drive(OP_LD, C_LW, 1, 0, rds[i], 0, 0);
            cycle();
            e = sb.pop_front();
            checks++;
            if (dut_bus !== e) begin
                errors++;
                $display("FAIL nfh_load%0d got=%h exp=%h", i, dut_bus, e);
            end
            drive(ops[i], C_ADD, (i == 1) ? 5'd1 : rds[i], rds[i], 8, 0, 0);
            #1;
            checks++;
            if ({NoOp_o, PCWrite_o} !== 2'b11) begin
                errors++;
                $display("FAIL nfh_use%0d got=%b exp=11", i, {NoOp_o, PCWrite_o});
            end
            cycle();
            void'(sb.pop_front());
        end
    endtask
    task automatic test_flush();
        drive(OP_REG, C_ADD | 8'b00001011, 3, 4, 9, 0, 1);
        Imm_i = 32'h10;
        cycle();
        e = sb.pop_front();
        checks++;
        if (dut_bus !== e || dut_bus[128:121] !== 8'b0 || Imm_o !== 32'h10 || RegWrite_o !== 1'b0) begin
            errors++;
            $display("FAIL flush got=%h exp=%h", dut_bus, e);
        end
    endtask
    task automatic test_flush_during_hold();
        logic [128:0] held;
        drive(OP_REG, C_ADD, 3, 4, 9, 0, 0);
        cycle();
        held = sb.pop_front();
        checks++;
        if (dut_bus !== held) begin
            errors++;
            $display("FAIL fdh_setup got=%h exp=%h", dut_bus, held);
        end
        for (int i = 0; i < 2; i++) begin
            drive(OP_REG, C_ADD, 10, 11, 12, 1, (i == 0));
            cycle();
            e = sb.pop_front();
            checks++;
            if (dut_bus !== held || dut_bus !== e) begin
                errors++;
                $display("FAIL fdh_hold%0d got=%h exp=%h", i, dut_bus, held);
            end
        end
        drive(OP_REG, C_ADD, 13, 14, 15, 0, 0);
        cycle();
        e = sb.pop_front();
        checks++;
        if (dut_bus !== e || dut_bus[128:121] !== 8'b0 || RDaddr_o !== 5'd15) begin
            errors++;
            $display("FAIL fdh_release got=%h exp=%h", dut_bus, e);
        end
        drive(OP_REG, C_ADD, 13, 14, 16, 0, 0);
        cycle();
        e = sb.pop_front();
        checks++;
        if (dut_bus !== e || RegWrite_o !== 1'b1) begin
            errors++;
            $display("FAIL fdh_pend_clear got=%h exp=%h", dut_bus, e);
        end
    endtask
    task automatic test_back_to_back();
        logic [6:0] ops[6] = '{OP_IMM, OP_REG, OP_LD, OP_ST, OP_BR, 7'b0110111};
        logic hz;
        for (int i = 0; i < 80; i++) begin
            drive(ops[$urandom_range(0, 5)], 8'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
            hz = model_hazard();
            if (hz) {ALUOp_i, ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i} = '0;
            #1;
            checks++;
            if ({NoOp_o, PCWrite_o, IFIDWrite_o} !== {~hz, ~(hz | Stall_i), ~(hz | Stall_i)}) begin
                errors++;
                $display("FAIL b2b_comb%0d got=%b exp=%b", i, {NoOp_o, PCWrite_o, IFIDWrite_o},
                         {~hz, ~(hz | Stall_i), ~(hz | Stall_i)});
            end
            cycle();
            e = sb.pop_front();
            checks++;
            if (dut_bus !== e) begin
                errors++;
                $display("FAIL b2b_regs%0d got=%h exp=%h", i, dut_bus, e);
            end
        end
    endtask
`ifdef ID_EX_PERF_CNT_EN
    task automatic test_perf_cnt();
        rst_i = 1;
        cycle();
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive(OP_IMM, 8'b0, 0, 0, 0, 1, 0);
            cycle();
            void'(sb.pop_front());
        end
        drive(OP_LD, C_LW, 1, 0, 5, 0, 0);
        cycle();
        void'(sb.pop_front());
        drive(OP_REG, 8'b0, 5, 1, 6, 0, 0);
        cycle();
        void'(sb.pop_front());
        checks++;
        if (HoldCnt_o !== 32'd3 || BubbleCnt_o !== 32'd1 || HoldCnt_o !== m_hold || BubbleCnt_o !== m_bub) begin
            errors++;
            $display("FAIL perf_counts got hold=%0d bub=%0d exp hold=3 bub=1", HoldCnt_o, BubbleCnt_o);
        end
        drive(OP_REG, 8'b0, 5, 1, 6, 1, 1);
        rst_i = 1;
        cycle();
        void'(sb.pop_front());
        checks++;
        if (HoldCnt_o !== 32'd0 || BubbleCnt_o !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset got hold=%0d bub=%0d exp 0", HoldCnt_o, BubbleCnt_o);
        end
    endtask
`endif
    initial begin
        {m_ctrl, m_rs1d, m_rs2d, m_imm, m_funct, m_a1, m_a2, m_rd, m_pend, m_bub, m_hold} = '0;
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_flush();
        test_flush_during_hold();
        test_back_to_back();
`ifdef ID_EX_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, directly downstream of the Control decoder.
- Latches decoded control bits, register-file data, immediate, funct and register addresses into EX.
- Contains load-use hazard detection. Produces NoOp_o, which drives the Control decoder's no-op input, plus the PC and IF/ID write enables.
- Also handles downstream hold (Stall_i) and branch flush (Flush_i), including a flush that arrives during a hold.

Parameters:
- DATA_W, 32, width of register data and immediate.
- REG_AW, 5, register address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- Op_i  in  7  opcode of the instruction currently in ID
- ALUOp_i  in  2  from Control
- ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i  in  1 each  from Control
- RS1data_i, RS2data_i, Imm_i  in  DATA_W  ID operands
- funct_i  in  10  {funct7, funct3}
- RS1addr_i, RS2addr_i, RDaddr_i  in  REG_AW  ID register addresses
- Stall_i  in  1  downstream hold request
- Flush_i  in  1  branch taken; squash the instruction in ID
- ALUOp_o ... MemtoReg_o, RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o  out  same widths  registered EX-stage copies
- NoOp_o  out  1  0 = Control must emit a bubble; 1 = normal
- PCWrite_o  out  1  PC update enable
- IFIDWrite_o  out  1  IF/ID register write enable

Behaviour:
- Reset (rst_i=1 at a clk_i edge): all registered outputs are 0 and the pending-flush flag is cleared. Reset has highest priority. Asserting reset mid-stall or mid-flush discards all state.
- Hazard detection is combinational from the ID inputs and registered outputs. hazard = MemRead_o & (RDaddr_o != 0) & (use_rs1 & RS1addr_i == RDaddr_o | use_rs2 & RS2addr_i == RDaddr_o).
  - use_rs1 = Op_i in {0010011, 0110011, 0000011, 0100011, 1100011}.
  - use_rs2 = Op_i in {0110011, 0100011, 1100011}.
- NoOp_o = ~hazard.
- PCWrite_o = IFIDWrite_o = ~(hazard | Stall_i).
- Register update priority per clock edge:
  - 1) rst_i.
  - 2) Stall_i=1: hold all registered outputs. If Flush_i=1 in the same cycle, set the pending-flush flag.
  - 3) Flush_i=1 or pending-flush=1: capture data and address fields, force all 8 control bits to 0, clear pending-flush.
  - 4) Otherwise capture all inputs. During a hazard, the Control inputs are already zero (NoOp_o=0), so the captured entry is a bubble.
- Latency: 1 cycle from ID inputs to EX outputs.
- Load-use produces exactly one bubble. After the bubble is captured, MemRead_o=0, so the hazard self-clears the next cycle.
- Hazard and Stall_i together: hold has priority. NoOp_o still reflects the hazard but has no effect while held.
- Hazard and Flush_i together: flush wins and the entry is a bubble. NoOp_o remains combinational.
- RDaddr_o=0 with MemRead_o=1 never signals a hazard.
- Unknown Op_i: use_rs1 = use_rs2 = 0, so no hazard.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, adds outputs BubbleCnt_o[31:0] and HoldCnt_o[31:0], both 0 on reset.
  - BubbleCnt_o increments on each edge where a hazard bubble or a flush is captured (priority 3 or 4 with hazard).
  - HoldCnt_o increments on each edge with Stall_i=1 and rst_i=0.
  - Both wrap from 0xFFFFFFFF to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: rst_i=1 for 2 cycles with random inputs -> all outputs 0, NoOp_o=1, PCWrite_o=1.
- Load-use:
  - lw x5 (MemRead_i=1, RDaddr_i=5) captured.
  - Next ID is add with RS2addr_i=5, Op_i=0110011 -> NoOp_o=0, PCWrite_o=0, IFIDWrite_o=0 for exactly 1 cycle.
  - Following cycle: RegWrite_o=0, MemRead_o=0 (bubble), then NoOp_o=1.
- No false hazard:
  - lw x0 followed by a use of x0 -> NoOp_o stays 1.
  - lw x6 followed by addi (Op_i=0010011) with RS2addr_i=6 -> NoOp_o stays 1.
- Flush: Flush_i=1 with RegWrite_i=1, Imm_i=0x10 -> next cycle RegWrite_o=0, all control bits 0, Imm_o=0x10.
- Flush during hold: Stall_i=1 and Flush_i=1 in cycle N, Stall_i=1 only in N+1, Stall_i=0 in N+2 -> outputs held through N+1; after N+2 all control bits 0 and pending flag cleared.
- ID_EX_PERF_CNT_EN: 3 hold cycles plus 1 load-use bubble -> HoldCnt_o=3, BubbleCnt_o=1. Reset mid-run -> both 0.
